// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: eight-digit display scan scheduler with dead-time blanking, blink and frame-aligned mask loads
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_en,
  input  logic [7:0] load_blink,
  output logic       load_ready,
  output logic [2:0] disp_bit,
  output logic       digit_on,
  output logic       frame_start,
  output logic       blink_phase
);
  localparam int CW = $clog2((SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC) + 1);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] L_SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] L_BLANK_LAST = CW'(BLANK_CYC == 0 ? 0 : BLANK_CYC - 1);
  localparam logic [BW-1:0] L_BLINK_LAST = BW'(BLINK_DIV - 1);
  typedef enum logic {SHOW, BLANK} state_t;
  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_en, r_blink, r_en_pend, r_blink_pend, w_en_nx, w_blink_nx;
  logic [BW-1:0] r_bcnt;
  logic          r_pend, r_ready, r_on, r_fs, r_phase;
  logic          w_show_done, w_adv, w_frame, w_accept, w_apply, w_phase_nx, w_on_nx, w_ready_nx;
  assign w_show_done = r_state == SHOW && r_cnt == L_SHOW_LAST;
  assign w_adv       = BLANK_CYC == 0 ? w_show_done : (r_state == BLANK && r_cnt == L_BLANK_LAST);
  assign w_frame     = w_adv && r_bit == 3'd7;
  assign w_accept    = load && r_ready;
  assign w_apply     = w_frame && r_pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SHOW;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_en         <= 8'hFF;
      r_blink      <= 8'h00;
      r_en_pend    <= 8'h00;
      r_blink_pend <= 8'h00;
      r_pend       <= 1'b0;
      r_ready      <= 1'b1;
      r_on         <= 1'b1;
      r_fs         <= 1'b0;
      r_bcnt       <= '0;
      r_phase      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_en    <= w_en_nx;
      r_blink <= w_blink_nx;
      r_ready <= w_ready_nx;
      r_on    <= w_on_nx;
      r_fs    <= w_frame;
      r_bcnt  <= r_bcnt == L_BLINK_LAST ? '0 : r_bcnt + BW'(1);
      r_phase <= w_phase_nx;
      if (w_accept) begin
        r_en_pend    <= load_en;
        r_blink_pend <= load_blink;
        r_pend       <= 1'b1;
      end else if (w_apply) r_pend <= 1'b0;
    end
  end
  always_comb begin
    w_state_nx = w_adv ? SHOW : (w_show_done ? BLANK : r_state);
    w_cnt_nx   = (w_adv || w_show_done) ? '0 : r_cnt + CW'(1);
    w_bit_nx   = w_adv ? r_bit + 3'd1 : r_bit;
  end
  // digit_on is computed from next-cycle values so it switches on the same edge as disp_bit
  always_comb begin
    w_en_nx    = w_apply ? r_en_pend : r_en;
    w_blink_nx = w_apply ? r_blink_pend : r_blink;
    w_phase_nx = r_phase ^ (r_bcnt == L_BLINK_LAST);
    w_on_nx    = w_state_nx == SHOW && w_en_nx[w_bit_nx] && !(w_blink_nx[w_bit_nx] && w_phase_nx);
    w_ready_nx = !w_accept && !r_pend;
  end
  assign load_ready  = r_ready;
  assign disp_bit    = r_bit;
  assign digit_on    = r_on;
  assign frame_start = r_fs;
  assign blink_phase = r_phase;
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan scheduler for the eight-digit seven-segment display. It time-shares the single segment driver among the eight digit positions by generating the 3-bit digit index consumed by the display digit multiplexer. It inserts a dead-time blanking interval between digits to suppress ghosting and applies per-digit enable and blink masks. New masks are loaded through a valid/ready handshake and take effect only at a frame boundary, so a frame is never torn.

## Interface
- SCAN_DIV, 100000: cycles each digit is shown per frame (≥2).
- BLANK_CYC, 1000: dead-time cycles after each digit (0 = no blanking).
- BLINK_DIV, 50000000: cycles per blink half-period (≥2).
- clk  in  1  system clock; everything is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  mask load request (valid).
- load_en  in  8  new digit enable mask; bit i = digit i.
- load_blink  in  8  new blink mask; bit i = digit i.
- load_ready  out  1  a load is accepted when load && load_ready.
- disp_bit  out  3  current digit index, driven to the digit mux.
- digit_on  out  1  1 = drive the anode of digit disp_bit; 0 = all anodes off.
- frame_start  out  1  one-cycle pulse on the first SHOW cycle of digit 0.
- blink_phase  out  1  current blink phase; 1 = blinking digits dark.

## Operation
- Two-state FSM per digit slot.
  - SHOW: lasts SCAN_DIV cycles.
  - BLANK: lasts BLANK_CYC cycles, with digit_on = 0.
  - SHOW→BLANK when div_cnt == SCAN_DIV−1. If BLANK_CYC = 0, go directly to the next digit's SHOW instead.
  - BLANK→SHOW when div_cnt == BLANK_CYC−1. disp_bit increments on this transition and wraps 7→0.
- div_cnt is cleared on every state transition.
- In SHOW: digit_on = en_reg[disp_bit] & ~(blink_reg[disp_bit] & blink_phase).
- A disabled or blinked-off digit still consumes its full slot, so scan timing is uniform.
- The disp_bit change and the forced-off value of digit_on are both registered outputs. They change on the same edge, so no glitch reaches the anodes.
- Shadow registers: en_pend and blink_pend, plus a pend flag.
  - Load accepted: capture both masks into the pend registers, set pend, and drop load_ready on the next cycle.
  - Load while load_ready = 0: ignored, and the pend contents are unchanged.
  - Frame boundary (the transition into digit 0's SHOW): if pend, copy pend→en_reg/blink_reg and clear pend. load_ready returns to 1 on the following cycle.
  - Digit 0's SHOW slot already uses the new masks.
- Blink: free-running counter 0..BLINK_DIV−1. blink_phase toggles on wrap. It is independent of scan state and of mask loads.

## Timing
- Reset values: disp_bit=0, FSM=SHOW, div_cnt=0, en_reg=8'hFF, blink_reg=8'h00, pend=0, load_ready=1, digit_on=1, frame_start=0, blink_phase=0, blink counter=0.
- Reset is synchronous and overrides everything, including mid-slot, mid-blank and a pending load. A pending load is discarded.
- Digit period = SCAN_DIV + BLANK_CYC cycles. Frame period = 8 × that.
- frame_start is high exactly one cycle per frame, on the first SHOW cycle of digit 0. It does not fire on the first frame after reset.
- Mask apply latency: from acceptance to effect is ≤ one frame plus one digit period.
- No combinational paths from inputs to outputs. load_ready depends only on registered pend.
- A load accepted in the same cycle as the frame boundary goes to pend and applies at the next frame. The previous pend contents are the ones applied at this boundary; pend was necessarily 0, since load_ready was high.

## Test plan
- Test parameters: SCAN_DIV=4, BLANK_CYC=2, BLINK_DIV=16.
- Reset release → disp_bit runs 0,1,…,7,0; each digit shows digit_on=1 for 4 cycles then 0 for 2; frame_start pulses every 48 cycles from the first wrap.
- BLANK_CYC=0 build → digit_on stays 1 continuously; disp_bit advances every 4 cycles; frame = 32 cycles.
- Load load_en=8'b1010_1010 mid-frame (digit 3) → load_ready falls next cycle; digits 3–7 keep showing; from the next digit 0, digit_on=1 only for odd digits; load_ready rises one cycle after that frame_start.
- Second load while load_ready=0 (load_en=8'h00) → ignored; the first mask is applied, not 8'h00.
- load_blink=8'h01, load_en=8'hFF → digit 0 is dark during slots where blink_phase=1 and lit otherwise; blink_phase toggles every 16 cycles.
- Assert rst for one cycle mid-BLANK of digit 5 with a load pending → next cycle disp_bit=0, digit_on=1, load_ready=1, en_reg=8'hFF; the pending mask is never applied.
